// File: rtl/ipsxe_floating_point_norm_seq_v1_0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipsxe_floating_point_norm_seq_v1_0_pkg
// Purpose  : Shared definitions for the sequential mantissa normalizer:
//            chunk width, default mantissa width, FSM state encodings and
//            width helper functions.
// Ports    : none (package)
// Revision : v1.0 - initial release
// ============================================================================
package ipsxe_floating_point_norm_seq_v1_0_pkg;

  localparam int CHUNK_W    = 16;
  localparam int DEF_CHUNKS = 3;
  localparam int MW         = CHUNK_W * DEF_CHUNKS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width needed to hold a leading-zero count in the range 0..mw.
  function automatic int lz_width(input int mw);
    return $clog2(mw + 1);
  endfunction

  // Width of the chunk index register (at least one bit).
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage : ipsxe_floating_point_norm_seq_v1_0_pkg
`default_nettype wire

// File: rtl/ipsxe_floating_point_norm_seq_v1_0_find_one.sv
`default_nettype none
// ============================================================================
// Module   : ipsxe_floating_point_find_one_16bit_v1_0
// Purpose  : Combinational 16-bit leading-one finder. Reports whether any bit
//            is set and the bit position of the most significant set bit.
// Ports    : i_data  [15:0] word to search
//            o_found        at least one bit of i_data is set
//            o_index [3:0]  position of the highest set bit (0 if none)
// Revision : v1.0 - initial release
// ============================================================================
module ipsxe_floating_point_find_one_16bit_v1_0
  import ipsxe_floating_point_norm_seq_v1_0_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_data,
  output logic               o_found,
  output logic [3:0]         o_index
);

  always_comb begin
    o_found = |i_data;
    o_index = 4'd0;
    // Ascending scan: the last hit written is the highest set bit.
    for (int i = 0; i < CHUNK_W; i++) begin
      if (i_data[i]) begin
        o_index = i[3:0];
      end
    end
  end

endmodule : ipsxe_floating_point_find_one_16bit_v1_0
`default_nettype wire

// File: rtl/ipsxe_floating_point_norm_seq_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : ipsxe_floating_point_norm_seq_v1_0
// Purpose  : Multi-cycle mantissa normalizer. Scans the mantissa one 16-bit
//            chunk per cycle (MSB chunk first) through a single shared
//            leading-one finder, then left-shifts the mantissa and lowers the
//            exponent by the leading-zero count in one barrel-shift cycle.
// Ports    : i_clk, i_rst (async, active high), i_flush (sync abort)
//            i_valid/o_ready   input handshake, i_mant [MW], i_exp [EXP_WIDTH]
//            o_valid/i_ready   output handshake, o_mant, o_exp, o_lz,
//            o_zero (input was zero), o_underflow (i_exp <= lz)
// Revision : v1.0 - initial release
// ============================================================================
module ipsxe_floating_point_norm_seq_v1_0
  import ipsxe_floating_point_norm_seq_v1_0_pkg::*;
#(
  parameter int CHUNKS    = 3,
  parameter int EXP_WIDTH = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_flush,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [CHUNK_W*CHUNKS-1:0]                i_mant,
  input  logic [EXP_WIDTH-1:0]                     i_exp,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [CHUNK_W*CHUNKS-1:0]                o_mant,
  output logic [EXP_WIDTH-1:0]                     o_exp,
  output logic [lz_width(CHUNK_W*CHUNKS)-1:0]      o_lz,
  output logic                                     o_zero,
  output logic                                     o_underflow
);

  localparam int MANT_W = CHUNK_W * CHUNKS;
  localparam int LZW    = lz_width(MANT_W);
  localparam int IDXW   = idx_width(CHUNKS);
  // Compare width: one bit wider than either operand so nothing wraps.
  localparam int CW     = ((EXP_WIDTH > LZW) ? EXP_WIDTH : LZW) + 1;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [MANT_W-1:0]   r_mant;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [IDXW-1:0]     r_idx;
  logic [LZW-1:0]      r_lz_acc;
  logic [LZW-1:0]      r_lz;

  logic [MANT_W-1:0]   r_o_mant;
  logic [EXP_WIDTH-1:0] r_o_exp;
  logic [LZW-1:0]      r_o_lz;
  logic                r_o_valid;
  logic                r_o_zero;
  logic                r_o_underflow;

  logic [CHUNK_W-1:0]  w_chunk;
  logic                w_found;
  logic [3:0]          w_index;
  logic [LZW-1:0]      w_lz_found;
  logic [CW-1:0]       w_exp_ext;
  logic [CW-1:0]       w_lz_ext;
  logic [CW-1:0]       w_exp_sub;
  logic                w_no_uf;
  logic [MANT_W-1:0]   w_stage [0:LZW];

  assign o_ready     = (r_state == ST_IDLE);
  assign o_valid     = r_o_valid;
  assign o_mant      = r_o_mant;
  assign o_exp       = r_o_exp;
  assign o_lz        = r_o_lz;
  assign o_zero      = r_o_zero;
  assign o_underflow = r_o_underflow;

  // Chunk mux feeding the shared finder, selected by the scan index.
  always_comb begin
    w_chunk = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (r_idx == IDXW'(c)) begin
        w_chunk = r_mant[c*CHUNK_W +: CHUNK_W];
      end
    end
  end

  ipsxe_floating_point_find_one_16bit_v1_0 u_find_one (
    .i_data  (w_chunk),
    .o_found (w_found),
    .o_index (w_index)
  );

  assign w_lz_found = r_lz_acc + LZW'(4'd15 - w_index);

  // Exponent adjust, evaluated in SHIFT against the registered lz.
  assign w_exp_ext = CW'(r_exp);
  assign w_lz_ext  = CW'(r_lz);
  assign w_no_uf   = (w_exp_ext > w_lz_ext);
  assign w_exp_sub = w_exp_ext - w_lz_ext;

  // Logarithmic barrel shifter: stage s shifts by 2**s when lz bit s is set.
  assign w_stage[0] = r_mant;
  generate
    for (genvar s = 0; s < LZW; s++) begin : g_shift
      assign w_stage[s+1] = r_lz[s] ? (w_stage[s] << (1 << s)) : w_stage[s];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_found)                 w_state_nxt = ST_SHIFT;
        else if (r_idx == IDXW'(0))  w_state_nxt = ST_DONE;
      end
      ST_SHIFT: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Flush outranks every other transition, including acceptance in IDLE.
    if (i_flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mant        <= '0;
      r_exp         <= '0;
      r_idx         <= '0;
      r_lz_acc      <= '0;
      r_lz          <= '0;
      r_o_mant      <= '0;
      r_o_exp       <= '0;
      r_o_lz        <= '0;
      r_o_valid     <= 1'b0;
      r_o_zero      <= 1'b0;
      r_o_underflow <= 1'b0;
    end else if (i_flush) begin
      r_o_valid     <= 1'b0;
      r_o_zero      <= 1'b0;
      r_o_underflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_mant   <= i_mant;
            r_exp    <= i_exp;
            r_idx    <= IDXW'(CHUNKS - 1);
            r_lz_acc <= '0;
          end
        end
        ST_SCAN: begin
          if (w_found) begin
            r_lz <= w_lz_found;
          end else begin
            r_lz_acc <= r_lz_acc + LZW'(CHUNK_W);
            if (r_idx == IDXW'(0)) begin
              r_o_mant      <= '0;
              r_o_exp       <= '0;
              r_o_lz        <= LZW'(MANT_W);
              r_o_zero      <= 1'b1;
              r_o_underflow <= 1'b0;
              r_o_valid     <= 1'b1;
            end else begin
              r_idx <= r_idx - IDXW'(1);
            end
          end
        end
        ST_SHIFT: begin
          r_o_lz    <= r_lz;
          r_o_zero  <= 1'b0;
          r_o_valid <= 1'b1;
          if (w_no_uf) begin
            r_o_mant      <= w_stage[LZW];
            r_o_exp       <= w_exp_sub[EXP_WIDTH-1:0];
            r_o_underflow <= 1'b0;
          end else begin
            r_o_mant      <= '0;
            r_o_exp       <= '0;
            r_o_underflow <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) r_o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : ipsxe_floating_point_norm_seq_v1_0
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_norm_seq_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipsxe_floating_point_norm_seq_v1_0
// Purpose  : Scoreboard bench for the sequential normalizer (CHUNKS=3,
//            EXP_WIDTH=8) using directed vectors with hand-computed results.
// Revision : v1.0 - initial release
// ============================================================================
module tb_ipsxe_floating_point_norm_seq_v1_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush, i_valid, i_ready;
  logic        o_ready, o_valid, o_zero, o_underflow;
  logic [47:0] i_mant, o_mant;
  logic [7:0]  i_exp, o_exp;
  logic [5:0]  o_lz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [47:0] mant;
    logic [7:0]  exp;
    logic [5:0]  lz;
    logic        zero;
    logic        uf;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ipsxe_floating_point_norm_seq_v1_0 #(.CHUNKS(3), .EXP_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mant      (i_mant),
    .i_exp       (i_exp),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_mant      (o_mant),
    .o_exp       (o_exp),
    .o_lz        (o_lz),
    .o_zero      (o_zero),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && o_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got mant %0h with no pending op", o_mant);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mant",      o_mant,          e.mant);
        chk("exp",       o_exp,           e.exp);
        chk("lz",        o_lz,            e.lz);
        chk("zero",      o_zero,          e.zero);
        chk("underflow", o_underflow,     e.uf);
        chk("latency",   64'(cyc - e.t0), 64'(e.lat));
      end
    end
    prev_valid = o_valid;
  end

  task automatic issue(input logic [47:0] m, input logic [7:0] e,
                       input logic [47:0] xm, input logic [7:0] xe,
                       input logic [5:0] xlz, input logic xz, input logic xu,
                       input int lat);
    exp_t x;
    int   n;
    @(posedge clk); #1;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) chk("ready_timeout", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_mant  = m;
    i_exp   = e;
    @(posedge clk); #1;
    i_valid = 1'b0;
    x.mant = xm; x.exp = xe; x.lz = xlz; x.zero = xz; x.uf = xu;
    x.t0 = cyc; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_mant = '0; i_exp = '0;
    #3;
    chk("rst_ready", o_ready, 1); chk("rst_valid", o_valid, 0);
    chk("rst_mant", o_mant, 0);   chk("rst_exp", o_exp, 0);
    chk("rst_lz", o_lz, 0);       chk("rst_zero", o_zero, 0);
    chk("rst_uf", o_underflow, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed vectors: mant, exp -> mant, exp, lz, zero, uf, latency
    issue(48'h8000_0000_0000, 8'd10,  48'h8000_0000_0000, 8'd10,  6'd0,  0, 0, 2);
    drain();
    issue(48'h0000_0001_0000, 8'd100, 48'h8000_0000_0000, 8'd69,  6'd31, 0, 0, 3);
    drain();
    issue(48'h0000_0000_0000, 8'd50,  48'h0000_0000_0000, 8'd0,   6'd48, 1, 0, 3);
    drain();
    issue(48'h0000_0000_0001, 8'd20,  48'h0000_0000_0000, 8'd0,   6'd47, 0, 1, 4);
    drain();
    issue(48'h0000_00FF_0000, 8'd200, 48'hFF00_0000_0000, 8'd176, 6'd24, 0, 0, 3);
    drain();
    // exp == lz is underflow; exp == lz+1 is the smallest legal result
    issue(48'h0000_8000_0000, 8'd16,  48'h0000_0000_0000, 8'd0,   6'd16, 0, 1, 3);
    drain();
    issue(48'h0000_8000_0000, 8'd17,  48'h8000_0000_0000, 8'd1,   6'd16, 0, 0, 3);
    drain();
    issue(48'h0000_0000_4000, 8'd255, 48'h8000_0000_0000, 8'd222, 6'd33, 0, 0, 4);
    drain();

    // Back-pressure: hold result, pulse i_valid, must not capture
    i_ready = 1'b0;
    issue(48'h4000_0000_1234, 8'd30,  48'h8000_0000_2468, 8'd29,  6'd1,  0, 0, 2);
    n = 0;
    while (!o_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_arrive", o_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_mant = 48'hFFFF_FFFF_FFFF; i_exp = 8'd1;
      @(negedge clk);
      chk("hold_valid", o_valid, 1);
      chk("hold_mant",  o_mant,  48'h8000_0000_2468);
      chk("hold_exp",   o_exp,   8'd29);
      chk("hold_ready", o_ready, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", o_ready, 1);
    chk("release_valid", o_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_capture_valid", o_valid, 0);
    end
    drain();

    // Flush in IDLE blocks acceptance
    @(posedge clk); #1;
    i_valid = 1'b1; i_flush = 1'b1; i_mant = 48'h8000_0000_0000; i_exp = 8'd10;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_ready", o_ready, 1);

    // Flush while in SHIFT: back to IDLE, no result
    @(posedge clk); #1;
    i_valid = 1'b1; i_mant = 48'h8000_0000_0000; i_exp = 8'd10;
    @(posedge clk); #1;             // accepted -> SCAN
    i_valid = 1'b0;
    @(posedge clk); #1;             // -> SHIFT
    chk("shift_not_ready", o_ready, 0);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_ready", o_ready, 1);
    chk("flush_valid", o_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_no_valid", o_valid, 0);
    end

    // Asynchronous reset in the middle of a SCAN
    @(posedge clk); #1;
    i_valid = 1'b1; i_mant = 48'h0; i_exp = 8'd50;
    @(posedge clk); #1;             // accepted -> SCAN
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", o_ready, 1); chk("arst_valid", o_valid, 0);
    chk("arst_mant", o_mant, 0);   chk("arst_exp", o_exp, 0);
    chk("arst_lz", o_lz, 0);       chk("arst_zero", o_zero, 0);
    chk("arst_uf", o_underflow, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arst_no_valid", o_valid, 0);
    end

    // Normal operation after recovery
    issue(48'h0123_4567_89AB, 8'd40,  48'h91A2_B3C4_D580, 8'd33,  6'd7,  0, 0, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ipsxe_floating_point_norm_seq_v1_0
`default_nettype wire
